housekeeping_spi: RTL and testbench

- SPI-slave register block for the SoC housekeeping interface. The external host reaches it through the pad SPI pins: CSB on mprj_io[3], SCK on mprj_io[4], SDI on mprj_io[2], SDO on mprj_io[1].
- Serves chip identification registers and drives the PLL, IRQ and external-reset control bits.
- The SPI pins are oversampled by the core clock; there is no SCK clock domain.

---
 rtl/hkspi_pkg.sv | 41 ++++
 rtl/housekeeping_spi_sync_edge.sv | 43 ++++
 rtl/housekeeping_spi.sv | 202 ++++++++++++++++++++
 tb/tb_housekeeping_spi.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hkspi_pkg.sv
// Shared definitions for the housekeeping SPI slave: command layout,
// register addresses, register reset values and the transaction state enum.
package hkspi_pkg;

    localparam int CMD_WRITE_BIT = 7;
    localparam int CMD_READ_BIT  = 6;
    localparam int CMD_COUNT_MSB = 5;
    localparam int CMD_COUNT_LSB = 3;

    localparam logic [7:0] REG_PLL_ENA    = 8'd8;
    localparam logic [7:0] REG_PLL_BYPASS = 8'd9;
    localparam logic [7:0] REG_IRQ        = 8'd10;
    localparam logic [7:0] REG_EXT_RESET  = 8'd11;
    localparam logic [7:0] REG_TRAP       = 8'd12;
    localparam logic [7:0] REG_PLL_TRIM0  = 8'd13;
    localparam logic [7:0] REG_PLL_TRIM1  = 8'd14;
    localparam logic [7:0] REG_PLL_TRIM2  = 8'd15;
    localparam logic [7:0] REG_PLL_TRIM3  = 8'd16;
    localparam logic [7:0] REG_PLL_SEL    = 8'd17;
    localparam logic [7:0] REG_PLL_DIV    = 8'd18;

    localparam logic [7:0] RST_PLL_ENA    = 8'h02;
    localparam logic [7:0] RST_PLL_BYPASS = 8'h01;
    localparam logic [7:0] RST_IRQ        = 8'h00;
    localparam logic [7:0] RST_EXT_RESET  = 8'h00;
    localparam logic [7:0] RST_PLL_TRIM0  = 8'hFF;
    localparam logic [7:0] RST_PLL_TRIM1  = 8'hEF;
    localparam logic [7:0] RST_PLL_TRIM2  = 8'hFF;
    localparam logic [7:0] RST_PLL_TRIM3  = 8'h03;
    localparam logic [7:0] RST_PLL_SEL    = 8'h12;
    localparam logic [7:0] RST_PLL_DIV    = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMMAND,
        ST_ADDRESS,
        ST_DATA,
        ST_DONE
    } hkspi_state_e;

endpackage

// File: rtl/housekeeping_spi_sync_edge.sv
// Brings the pad SPI pins into the core clock domain and flags SCK rising edges.
module spi_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic csb,
    input  logic sck,
    input  logic sdi,
    output logic csb_level,
    output logic sck_rise,
    output logic sdi_level
);

    logic csb_meta, csb_sync;
    logic sck_meta, sck_sync, sck_prev;
    logic sdi_meta, sdi_sync;

    // CSB resets to "selected" so a window already open at reset release
    // is never mistaken for a fresh one.
    always_ff @(posedge clock) begin
        if (reset) begin
            csb_meta <= 1'b0;
            csb_sync <= 1'b0;
            sck_meta <= 1'b0;
            sck_sync <= 1'b0;
            sck_prev <= 1'b0;
            sdi_meta <= 1'b0;
            sdi_sync <= 1'b0;
        end else begin
            csb_meta <= csb;
            csb_sync <= csb_meta;
            sck_meta <= sck;
            sck_sync <= sck_meta;
            sck_prev <= sck_sync;
            sdi_meta <= sdi;
            sdi_sync <= sdi_meta;
        end
    end

    assign csb_level = csb_sync;
    assign sck_rise  = sck_sync & ~sck_prev;
    assign sdi_level = sdi_sync;

endmodule

// File: rtl/housekeeping_spi.sv
// Housekeeping SPI slave: oversampled SPI framing, ID/PLL/IRQ/reset register
// file and read-back shifter, all in the core clock domain.
module housekeeping_spi
    import hkspi_pkg::*;
#(
    parameter logic [11:0] MFGR_ID = 12'h456,
    parameter logic [7:0]  PROD_ID = 8'h11,
    parameter logic [31:0] USER_ID = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spi_csb,
    input  logic        spi_sck,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    output logic        spi_sdo_enb,
    input  logic        trap,
    output logic        ext_reset,
    output logic        irq,
    output logic        pll_ena,
    output logic        pll_dco_ena,
    output logic        pll_bypass,
    output logic [25:0] pll_trim,
    output logic [2:0]  pll_sel,
    output logic [2:0]  pll90_sel,
    output logic [4:0]  pll_div
);

    logic csb_s, sck_rise, sdi_s;

    spi_sync_edge u_sync (
        .clock     (clock),
        .reset     (reset),
        .csb       (spi_csb),
        .sck       (spi_sck),
        .sdi       (spi_sdi),
        .csb_level (csb_s),
        .sck_rise  (sck_rise),
        .sdi_level (sdi_s)
    );

    hkspi_state_e state, state_next;

    logic       armed;
    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic [7:0] new_byte;
    logic       cmd_write, cmd_read;
    logic [2:0] cmd_count;
    logic [2:0] data_cnt;
    logic [7:0] addr;
    logic [7:0] out_shift;
    logic       active, byte_done, last_data, reg_we;
    logic [7:0] load_addr, read_data;

    logic [1:0] pll_ctrl_q;
    logic       bypass_q, irq_q, ext_reset_q;
    logic [7:0] trim0_q, trim1_q, trim2_q;
    logic [1:0] trim3_q;
    logic [5:0] sel_q;
    logic [4:0] div_q;

    assign active    = (state == ST_COMMAND) || (state == ST_ADDRESS) || (state == ST_DATA);
    assign new_byte  = {shift_in, sdi_s};
    assign byte_done = active && !csb_s && sck_rise && (bit_cnt == 3'd7);
    assign last_data = (cmd_count != 3'd0) && (3'(data_cnt + 3'd1) == cmd_count);
    assign reg_we    = byte_done && (state == ST_DATA) && cmd_write;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (!csb_s && armed) state_next = ST_COMMAND;
            ST_COMMAND: if (byte_done) state_next = ST_ADDRESS;
            ST_ADDRESS: if (byte_done) state_next = ST_DATA;
            ST_DATA:    if (byte_done && last_data) state_next = ST_DONE;
            ST_DONE:    state_next = ST_DONE;
            default:    state_next = ST_IDLE;
        endcase
        if (csb_s) state_next = ST_IDLE;
    end

    // armed stays clear after reset until CSB is seen high, so the tail of a
    // window interrupted by reset is ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            armed     <= 1'b0;
            bit_cnt   <= 3'd0;
            shift_in  <= 7'd0;
            cmd_write <= 1'b0;
            cmd_read  <= 1'b0;
            cmd_count <= 3'd0;
            data_cnt  <= 3'd0;
            addr      <= 8'd0;
            out_shift <= 8'd0;
        end else begin
            if (csb_s) armed <= 1'b1;
            if (csb_s || !active) begin
                bit_cnt <= 3'd0;
                if (state == ST_IDLE) data_cnt <= 3'd0;
            end else if (sck_rise) begin
                shift_in  <= new_byte[6:0];
                bit_cnt   <= bit_cnt + 3'd1;
                out_shift <= {out_shift[6:0], 1'b0};
                if (bit_cnt == 3'd7) begin
                    unique case (state)
                        ST_COMMAND: begin
                            cmd_write <= new_byte[CMD_WRITE_BIT];
                            cmd_read  <= new_byte[CMD_READ_BIT];
                            cmd_count <= new_byte[CMD_COUNT_MSB:CMD_COUNT_LSB];
                        end
                        ST_ADDRESS: begin
                            addr      <= new_byte;
                            out_shift <= read_data;
                        end
                        ST_DATA: begin
                            addr      <= addr + 8'd1;
                            data_cnt  <= data_cnt + 3'd1;
                            out_shift <= read_data;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Byte loaded for read-out: the address itself at the end of the address
    // byte, the next address at the end of each data byte.
    always_comb begin
        load_addr = (state == ST_ADDRESS) ? new_byte : addr + 8'd1;
        read_data = 8'h00;
        case (load_addr)
            8'd1:           read_data = {4'h0, MFGR_ID[11:8]};
            8'd2:           read_data = MFGR_ID[7:0];
            8'd3:           read_data = PROD_ID;
            8'd4:           read_data = USER_ID[31:24];
            8'd5:           read_data = USER_ID[23:16];
            8'd6:           read_data = USER_ID[15:8];
            8'd7:           read_data = USER_ID[7:0];
            REG_PLL_ENA:    read_data = {6'h0, pll_ctrl_q};
            REG_PLL_BYPASS: read_data = {7'h0, bypass_q};
            REG_IRQ:        read_data = {7'h0, irq_q};
            REG_EXT_RESET:  read_data = {7'h0, ext_reset_q};
            REG_TRAP:       read_data = {7'h0, trap};
            REG_PLL_TRIM0:  read_data = trim0_q;
            REG_PLL_TRIM1:  read_data = trim1_q;
            REG_PLL_TRIM2:  read_data = trim2_q;
            REG_PLL_TRIM3:  read_data = {6'h0, trim3_q};
            REG_PLL_SEL:    read_data = {2'h0, sel_q};
            REG_PLL_DIV:    read_data = {3'h0, div_q};
            default:        read_data = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pll_ctrl_q  <= RST_PLL_ENA[1:0];
            bypass_q    <= RST_PLL_BYPASS[0];
            irq_q       <= RST_IRQ[0];
            ext_reset_q <= RST_EXT_RESET[0];
            trim0_q     <= RST_PLL_TRIM0;
            trim1_q     <= RST_PLL_TRIM1;
            trim2_q     <= RST_PLL_TRIM2;
            trim3_q     <= RST_PLL_TRIM3[1:0];
            sel_q       <= RST_PLL_SEL[5:0];
            div_q       <= RST_PLL_DIV[4:0];
        end else if (reg_we) begin
            case (addr)
                REG_PLL_ENA:    pll_ctrl_q  <= new_byte[1:0];
                REG_PLL_BYPASS: bypass_q    <= new_byte[0];
                REG_IRQ:        irq_q       <= new_byte[0];
                REG_EXT_RESET:  ext_reset_q <= new_byte[0];
                REG_PLL_TRIM0:  trim0_q     <= new_byte;
                REG_PLL_TRIM1:  trim1_q     <= new_byte;
                REG_PLL_TRIM2:  trim2_q     <= new_byte;
                REG_PLL_TRIM3:  trim3_q     <= new_byte[1:0];
                REG_PLL_SEL:    sel_q       <= new_byte[5:0];
                REG_PLL_DIV:    div_q       <= new_byte[4:0];
                default: ;
            endcase
        end
    end

    assign spi_sdo_enb = !((state == ST_DATA) && cmd_read && !csb_s);
    assign spi_sdo     = !spi_sdo_enb && out_shift[7];

    assign pll_ena     = pll_ctrl_q[0];
    assign pll_dco_ena = pll_ctrl_q[1];
    assign pll_bypass  = bypass_q;
    assign irq         = irq_q;
    assign ext_reset   = ext_reset_q;
    assign pll_trim    = {trim3_q, trim2_q, trim1_q, trim0_q};
    assign pll_sel     = sel_q[2:0];
    assign pll90_sel   = sel_q[5:3];
    assign pll_div     = div_q;

endmodule

// File: tb/tb_housekeeping_spi.sv
// Directed bench for housekeeping_spi: drives SPI as a host with slow SCK and
// compares read-back bytes and control outputs against hand-computed values.
module tb_housekeeping_spi;

    localparam int HALF = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        spi_csb = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_sdi = 1'b0;
    logic        trap = 1'b0;
    logic        spi_sdo, spi_sdo_enb;
    logic        ext_reset, irq, pll_ena, pll_dco_ena, pll_bypass;
    logic [25:0] pll_trim;
    logic [2:0]  pll_sel, pll90_sel;
    logic [4:0]  pll_div;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx, enb;

    housekeeping_spi dut (
        .clock       (clock),
        .reset       (reset),
        .spi_csb     (spi_csb),
        .spi_sck     (spi_sck),
        .spi_sdi     (spi_sdi),
        .spi_sdo     (spi_sdo),
        .spi_sdo_enb (spi_sdo_enb),
        .trap        (trap),
        .ext_reset   (ext_reset),
        .irq         (irq),
        .pll_ena     (pll_ena),
        .pll_dco_ena (pll_dco_ena),
        .pll_bypass  (pll_bypass),
        .pll_trim    (pll_trim),
        .pll_sel     (pll_sel),
        .pll90_sel   (pll90_sel),
        .pll_div     (pll_div)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic spi_begin();
        @(negedge clock);
        spi_csb = 1'b0;
        repeat (HALF) @(negedge clock);
    endtask

    task automatic spi_end();
        repeat (HALF) @(negedge clock);
        spi_csb = 1'b1;
        repeat (2 * HALF) @(negedge clock);
    endtask

    // Host samples SDO and the enable at the end of each SCK low phase.
    task automatic spi_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx_o, output logic [7:0] enb_o);
        rx_o  = 8'h00;
        enb_o = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_sdi = tx[7-i];
            repeat (HALF) @(negedge clock);
            rx_o[7-i]  = spi_sdo;
            enb_o[7-i] = spi_sdo_enb;
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clock);
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx_o, output logic [7:0] enb_o);
        spi_bits(tx, 8, rx_o, enb_o);
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r, e;
        spi_begin();
        spi_byte(8'h80, r, e);
        spi_byte(a, r, e);
        spi_byte(d, r, e);
        spi_end();
    endtask

    task automatic reg_read(input logic [7:0] a, output logic [7:0] d);
        logic [7:0] e;
        spi_begin();
        spi_byte(8'h40, d, e);
        spi_byte(a, d, e);
        spi_byte(8'h00, d, e);
        spi_end();
    endtask

    initial begin
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        check_eq("rst_sdo_enb", spi_sdo_enb, 1);
        check_eq("rst_sdo", spi_sdo, 0);
        check_eq("rst_ext_reset", ext_reset, 0);
        check_eq("rst_irq", irq, 0);
        check_eq("rst_pll_ena", pll_ena, 0);
        check_eq("rst_pll_dco_ena", pll_dco_ena, 1);
        check_eq("rst_pll_bypass", pll_bypass, 1);
        check_eq("rst_pll_trim", pll_trim, 26'h3FFEFFF);
        check_eq("rst_pll_sel", pll_sel, 3'd2);
        check_eq("rst_pll90_sel", pll90_sel, 3'd2);
        check_eq("rst_pll_div", pll_div, 5'd4);

        // Single read of product ID, with enable window checks.
        spi_begin();
        spi_byte(8'h40, rx, enb);
        check_eq("rd3_cmd_enb", enb, 8'hFF);
        spi_byte(8'h03, rx, enb);
        check_eq("rd3_addr_enb", enb, 8'hFF);
        spi_byte(8'h00, rx, enb);
        check_eq("rd3_data", rx, 8'h11);
        check_eq("rd3_data_enb", enb, 8'h00);
        spi_end();
        check_eq("rd3_post_enb", spi_sdo_enb, 1);
        check_eq("rd3_post_sdo", spi_sdo, 0);

        // Streaming read of the whole defined map.
        exp_q = '{8'h00, 8'h04, 8'h56, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01,
                  8'h00, 8'h00, 8'h00, 8'hFF, 8'hEF, 8'hFF, 8'h03, 8'h12, 8'h04};
        spi_begin();
        spi_byte(8'h40, rx, enb);
        spi_byte(8'h00, rx, enb);
        for (int i = 0; i < 19; i++) begin
            spi_byte(8'h00, rx, enb);
            check_eq($sformatf("stream_%0d", i), rx, exp_q.pop_front());
        end
        spi_end();

        reg_write(8'h0B, 8'h01);
        check_eq("ext_reset_set", ext_reset, 1);
        reg_write(8'h0B, 8'h00);
        check_eq("ext_reset_clr", ext_reset, 0);
        reg_read(8'h0B, rx);
        check_eq("rd11", rx, 8'h00);

        reg_write(8'h12, 8'h1F);
        check_eq("pll_div_1f", pll_div, 5'h1F);
        spi_begin();
        spi_byte(8'hC0, rx, enb);
        spi_byte(8'h12, rx, enb);
        spi_byte(8'h07, rx, enb);
        check_eq("rw_prewrite", rx, 8'h1F);
        spi_end();
        check_eq("pll_div_7", pll_div, 5'h07);

        reg_write(8'h03, 8'hAA);
        reg_read(8'h03, rx);
        check_eq("rd3_readonly", rx, 8'h11);

        // Count mode N=1: second data byte must be silent.
        spi_begin();
        spi_byte(8'h48, rx, enb);
        spi_byte(8'h11, rx, enb);
        spi_byte(8'h00, rx, enb);
        check_eq("cnt1_data", rx, 8'h12);
        check_eq("cnt1_data_enb", enb, 8'h00);
        spi_byte(8'hFF, rx, enb);
        check_eq("cnt1_over_sdo", rx, 8'h00);
        check_eq("cnt1_over_enb", enb, 8'hFF);
        spi_end();

        reg_read(8'h13, rx);
        check_eq("rd19_unmapped", rx, 8'h00);

        trap = 1'b1;
        reg_read(8'h0C, rx);
        check_eq("rd12_trap", rx, 8'h01);
        trap = 1'b0;

        // Abort mid data byte: no write to reg 9.
        spi_begin();
        spi_byte(8'h80, rx, enb);
        spi_byte(8'h09, rx, enb);
        spi_bits(8'h00, 4, rx, enb);
        spi_end();
        check_eq("abort_bypass", pll_bypass, 1);
        reg_read(8'h09, rx);
        check_eq("abort_rd9", rx, 8'h01);

        reg_write(8'h08, 8'h01);
        check_eq("wr8_pll_ena", pll_ena, 1);
        check_eq("wr8_pll_dco_ena", pll_dco_ena, 0);

        // Reset mid-stream; remaining bytes in the window must be ignored.
        spi_begin();
        spi_byte(8'h80, rx, enb);
        spi_byte(8'h0D, rx, enb);
        spi_byte(8'h00, rx, enb);
        check_eq("mid_trim_written", pll_trim, 26'h3FFEF00);
        spi_bits(8'h00, 3, rx, enb);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        spi_byte(8'h00, rx, enb);
        spi_byte(8'h00, rx, enb);
        spi_end();
        check_eq("mid_rst_trim", pll_trim, 26'h3FFEFFF);
        check_eq("mid_rst_pll_ena", pll_ena, 0);
        check_eq("mid_rst_dco_ena", pll_dco_ena, 1);
        check_eq("mid_rst_pll_div", pll_div, 5'd4);
        reg_read(8'h0D, rx);
        check_eq("mid_rst_rd13", rx, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
